// File: rtl/key_expansion.sv
// AES-256 key schedule: fills w8..w59 one word per clock after reset release
// and serves 128-bit round keys. Also exposes combinational SubBytes and
// MixColumns ports (forward or inverse) for the cipher datapath.
module key_expansion (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [255:0]      key_in,
    input  logic [3:0]        current_state,
    input  logic [3:0]        round,
    input  logic signed [4:0] cnt,
    input  logic              inv_en,
    output logic [127:0]      round_key_o,
    output logic              key_ready,
    input  logic [7:0]        sb_in,
    output logic [7:0]        sb_out,
    input  logic [31:0]       mc_in,
    output logic [31:0]       mc_out
);

    // GF(2^8) multiply, reduction polynomial 0x11B
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 = product of a^(2^k), k=1..7; maps 0 to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] x;
        logic [7:0] r;
        x = a;
        r = 8'h01;
        for (int k = 1; k < 8; k++) begin
            x = gf_mul(x, x);
            r = gf_mul(r, x);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] a);
        return gf_inv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_fwd(w[31:24]), sbox_fwd(w[23:16]), sbox_fwd(w[15:8]), sbox_fwd(w[7:0])};
    endfunction

    // Column mix with coefficient row {c0,c1,c2,c3}, rotated right per output byte
    function automatic logic [31:0] mix_col(input logic [31:0] s, input logic [7:0] c0,
                                            input logic [7:0] c1, input logic [7:0] c2,
                                            input logic [7:0] c3);
        logic [7:0] s0, s1, s2, s3;
        s0 = s[31:24];
        s1 = s[23:16];
        s2 = s[15:8];
        s3 = s[7:0];
        return {gf_mul(c0, s0) ^ gf_mul(c1, s1) ^ gf_mul(c2, s2) ^ gf_mul(c3, s3),
                gf_mul(c3, s0) ^ gf_mul(c0, s1) ^ gf_mul(c1, s2) ^ gf_mul(c2, s3),
                gf_mul(c2, s0) ^ gf_mul(c3, s1) ^ gf_mul(c0, s2) ^ gf_mul(c1, s3),
                gf_mul(c1, s0) ^ gf_mul(c2, s1) ^ gf_mul(c3, s2) ^ gf_mul(c0, s3)};
    endfunction

    logic [31:0]  w_lo_q [0:7];
    logic [31:0]  w_hi_q [8:59];
    logic [31:0]  w_all  [0:59];
    logic [5:0]   ptr_q;
    logic         ready_q;
    logic [127:0] round_key_q;

    logic         filling;
    logic [5:0]   fill_ptr;
    logic [31:0]  prev_word;
    logic [31:0]  sub_in;
    logic [31:0]  sub_res;
    logic [7:0]   rcon;
    logic [31:0]  temp;
    logic [31:0]  new_word;
    logic [5:0]   rk_base;
    logic [127:0] rk_d;

    // The controller's state and step counter are informational only here
    logic unused_inputs;
    assign unused_inputs = ^{current_state, cnt};

    // Flatten the key words and the generated words into one read view
    always_comb begin
        for (int i = 0; i < 8; i++) w_all[i] = w_lo_q[i];
        for (int i = 8; i < 60; i++) w_all[i] = w_hi_q[i];
    end

    // Next schedule word; pointer is clamped so reads stay in range once full
    always_comb begin
        filling   = (ptr_q <= 6'd59);
        fill_ptr  = filling ? ptr_q : 6'd59;
        prev_word = w_all[fill_ptr - 6'd1];
        sub_in    = (fill_ptr[2:0] == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;
        sub_res   = sub_word(sub_in);
        case (fill_ptr[5:3])
            3'd1:    rcon = 8'h01;
            3'd2:    rcon = 8'h02;
            3'd3:    rcon = 8'h04;
            3'd4:    rcon = 8'h08;
            3'd5:    rcon = 8'h10;
            3'd6:    rcon = 8'h20;
            3'd7:    rcon = 8'h40;
            default: rcon = 8'h00;
        endcase
        if (fill_ptr[2:0] == 3'd0)      temp = sub_res ^ {rcon, 24'h000000};
        else if (fill_ptr[2:0] == 3'd4) temp = sub_res;
        else                            temp = prev_word;
        new_word = w_all[fill_ptr - 6'd8] ^ temp;
    end

    // Round key selection; index 15 reads as zero
    always_comb begin
        rk_base = {round, 2'b00};
        rk_d    = 128'h0;
        if (round != 4'd15) begin
            rk_d = {w_all[rk_base], w_all[rk_base + 6'd1],
                    w_all[rk_base + 6'd2], w_all[rk_base + 6'd3]};
        end
    end

    // Key words track key_in while reset is held; the rest clears and refills after release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) w_lo_q[i] <= key_in[255 - 32*i -: 32];
            for (int i = 8; i < 60; i++) w_hi_q[i] <= 32'h0;
            ptr_q       <= 6'd8;
            ready_q     <= 1'b0;
            round_key_q <= 128'h0;
        end else begin
            if (filling) begin
                w_hi_q[ptr_q] <= new_word;
                ptr_q         <= ptr_q + 6'd1;
                if (ptr_q == 6'd59) ready_q <= 1'b1;
            end
            round_key_q <= rk_d;
        end
    end

    // Datapath helper ports, purely combinational
    always_comb begin
        sb_out = inv_en ? sbox_inv(sb_in) : sbox_fwd(sb_in);
        mc_out = inv_en ? mix_col(mc_in, 8'h0e, 8'h0b, 8'h0d, 8'h09)
                        : mix_col(mc_in, 8'h02, 8'h03, 8'h01, 8'h01);
    end

    assign round_key_o = round_key_q;
    assign key_ready   = ready_q;

endmodule

// File: tb/tb_key_expansion.sv
// Self-checking bench for key_expansion: a reference key schedule and
// S-box/mix model, checked every cycle, plus literal known-answer checks.
module tb_key_expansion;

    localparam logic [255:0] KEY_A =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [255:0]      key_in;
    logic [3:0]        current_state;
    logic [3:0]        round;
    logic signed [4:0] cnt;
    logic              inv_en;
    logic [127:0]      round_key_o;
    logic              key_ready;
    logic [7:0]        sb_in;
    logic [7:0]        sb_out;
    logic [31:0]       mc_in;
    logic [31:0]       mc_out;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    logic [7:0]   sbox_t  [256];
    logic [7:0]   isbox_t [256];
    logic [31:0]  ew      [60];
    int           edges;
    logic [127:0] exp_rk;
    logic         exp_ready;

    always #5 clk = ~clk;

    key_expansion dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_in        (key_in),
        .current_state (current_state),
        .round         (round),
        .cnt           (cnt),
        .inv_en        (inv_en),
        .round_key_o   (round_key_o),
        .key_ready     (key_ready),
        .sb_in         (sb_in),
        .sb_out        (sb_out),
        .mc_in         (mc_in),
        .mc_out        (mc_out)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // S-box built by walking the multiplicative group with generator 3
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox_t[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_t[0] = 8'h63;
        for (int i = 0; i < 256; i++) isbox_t[sbox_t[i]] = 8'(i);
    endtask

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mulc(input logic [7:0] x, input int c);
        logic [7:0] x2, x4, x8;
        x2 = xt(x);
        x4 = xt(x2);
        x8 = xt(x4);
        case (c)
            1:       return x;
            2:       return x2;
            3:       return x2 ^ x;
            9:       return x8 ^ x;
            11:      return x8 ^ x2 ^ x;
            13:      return x8 ^ x4 ^ x;
            14:      return x8 ^ x4 ^ x2;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] model_mix(input logic [31:0] s, input logic inv);
        int         c [4];
        logic [7:0] b [4];
        logic [7:0] r;
        logic [31:0] out;
        if (inv) begin c[0] = 14; c[1] = 11; c[2] = 13; c[3] = 9; end
        else     begin c[0] = 2;  c[1] = 3;  c[2] = 1;  c[3] = 1; end
        for (int j = 0; j < 4; j++) b[j] = s[31 - 8*j -: 8];
        out = 32'h0;
        for (int i = 0; i < 4; i++) begin
            r = 8'h00;
            for (int j = 0; j < 4; j++) r = r ^ mulc(b[j], c[(j - i + 4) % 4]);
            out[31 - 8*i -: 8] = r;
        end
        return out;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    task automatic build_schedule(input logic [255:0] k);
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 8; i++) ew[i] = k[255 - 32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = ew[i-1];
            if (i % 8 == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (i % 8 == 4) begin
                t = subw(t);
            end
            ew[i] = ew[i-8] ^ t;
        end
    endtask

    // Reference: words past the fill front read as zero, everything else from the schedule
    always @(posedge clk) begin
        if (!rst_n) begin
            build_schedule(key_in);
            edges     = 0;
            exp_rk    = 128'h0;
            exp_ready = 1'b0;
        end else begin
            exp_rk = 128'h0;
            if (round != 4'd15) begin
                for (int j = 0; j < 4; j++) begin
                    int idx;
                    idx = 4 * int'(round) + j;
                    if (idx < 8 + edges) exp_rk[127 - 32*j -: 32] = ew[idx];
                end
            end
            edges     = edges + 1;
            exp_ready = (edges >= 52);
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("round_key", round_key_o, exp_rk);
            chk("key_ready", {127'h0, key_ready}, {127'h0, exp_ready});
            chk("sb_out", {120'h0, sb_out}, {120'h0, inv_en ? isbox_t[sb_in] : sbox_t[sb_in]});
            chk("mc_out", {96'h0, mc_out}, {96'h0, model_mix(mc_in, inv_en)});
        end
    end

    task automatic rand_inputs(input bit rand_round);
        if (rand_round) round = 4'($urandom_range(0, 15));
        inv_en        = 1'($urandom_range(0, 1));
        sb_in         = 8'($urandom);
        mc_in         = $urandom;
        current_state = 4'($urandom);
        cnt           = 5'($urandom);
    endtask

    // Starts and ends at negedge+1
    task automatic rk_check(input logic [3:0] r, input logic [127:0] exp, input string nm);
        round = r;
        @(negedge clk);
        chk(nm, round_key_o, exp);
        #1;
    endtask

    task automatic sb_check(input logic inv, input logic [7:0] din, input logic [7:0] exp);
        inv_en = inv;
        sb_in  = din;
        @(negedge clk);
        chk("sb_literal", {120'h0, sb_out}, {120'h0, exp});
        #1;
    endtask

    task automatic mc_check(input logic inv, input logic [31:0] din, input logic [31:0] exp);
        inv_en = inv;
        mc_in  = din;
        @(negedge clk);
        chk("mc_literal", {96'h0, mc_out}, {96'h0, exp});
        #1;
    endtask

    // Counts 52 fill edges after a release at negedge+1, pinning key_ready timing
    task automatic fill_and_check(input string nm);
        for (int k = 1; k <= 52; k++) begin
            @(negedge clk);
            if (k == 51) chk({nm, "_ready_at_51"}, {127'h0, key_ready}, 128'h0);
            if (k == 52) chk({nm, "_ready_at_52"}, {127'h0, key_ready}, 128'h1);
            #1;
            rand_inputs(1'b1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

    initial begin
        build_sbox();
        rst_n         = 1'b0;
        key_in        = KEY_A;
        round         = 4'd0;
        inv_en        = 1'b0;
        sb_in         = 8'h00;
        mc_in         = 32'h0;
        current_state = 4'd0;
        cnt           = 5'sd0;

        repeat (3) @(negedge clk);
        check_en = 1'b1;
        chk("reset_round_key", round_key_o, 128'h0);
        chk("reset_key_ready", {127'h0, key_ready}, 128'h0);
        #1 rst_n = 1'b1;
        fill_and_check("fill1");

        rk_check(4'd0,  128'h000102030405060708090a0b0c0d0e0f, "rk0_literal");
        rk_check(4'd1,  128'h101112131415161718191a1b1c1d1e1f, "rk1_literal");
        rk_check(4'd2,  128'ha573c29fa176c498a97fce93a572c09c, "rk2_literal");
        rk_check(4'd14, 128'h24fc79ccbf0979e9371ac23c6d68de36, "rk14_literal");
        rk_check(4'd15, 128'h0, "rk15_zero");

        sb_check(1'b0, 8'h00, 8'h63);
        sb_check(1'b0, 8'h01, 8'h7c);
        sb_check(1'b0, 8'h53, 8'hed);
        sb_check(1'b1, 8'h63, 8'h00);
        sb_check(1'b1, 8'hed, 8'h53);
        mc_check(1'b0, 32'hdb135345, 32'h8e4da1bc);
        mc_check(1'b0, 32'h01010101, 32'h01010101);
        mc_check(1'b1, 32'h8e4da1bc, 32'hdb135345);

        // key_in changes with reset released must not disturb the table
        key_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        repeat (20) begin
            @(negedge clk);
            #1 rand_inputs(1'b1);
        end
        rk_check(4'd14, 128'h24fc79ccbf0979e9371ac23c6d68de36, "rk14_after_key_change");

        // Reset pulse 20 edges into a fill, then a full refill
        rst_n  = 1'b0;
        key_in = KEY_A;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            #1 rand_inputs(1'b0);
            round = 4'd1;
        end
        rst_n = 1'b0;
        #1;
        chk("midfill_async_round_key", round_key_o, 128'h0);
        chk("midfill_async_key_ready", {127'h0, key_ready}, 128'h0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        fill_and_check("refill");
        rk_check(4'd14, 128'h24fc79ccbf0979e9371ac23c6d68de36, "rk14_after_refill");

        // Random keys, random rounds during and after the fill
        for (int n = 0; n < 3; n++) begin
            rst_n  = 1'b0;
            key_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            repeat (2) @(negedge clk);
            #1 rst_n = 1'b1;
            repeat (70) begin
                @(negedge clk);
                #1 rand_inputs(1'b1);
            end
        end

        @(negedge clk);
        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/key_expansion.md
KEY_EXPANSION -- requirements
Module: key_expansion

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all registers.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 key_in  input  256  AES-256 master key; word w0 = key_in[255:224], w7 = key_in[31:0].
REQ-005 current_state  input  4  cipher controller state; no functional effect in this block.
REQ-006 round  input  4  round-key index, 0..14.
REQ-007 cnt  input  5 (signed)  controller step counter; no functional effect in this block.
REQ-008 inv_en  input  1  0 = forward, 1 = inverse; selects the sb_out and mc_out functions only.
REQ-009 round_key_o  output  128  registered round key for index round.
REQ-010 key_ready  output  1  high once all 60 schedule words are valid.
REQ-011 sb_in / sb_out  input/output  8  combinational SubBytes port: S-box when inv_en=0, inverse S-box when inv_en=1.
REQ-012 mc_in / mc_out  input/output  32  combinational column port: MixColumns when inv_en=0, InvMixColumns when inv_en=1.

Function
REQ-013 An internal table SHALL hold 60 32-bit words, w0..w59, per the FIPS-197 AES-256 key schedule.
REQ-014 While rst_n=0, the table SHALL load w0..w7 from key_in.
REQ-015 Fill order SHALL be one word per rising clk edge after reset release: w8 first, w59 last, so w8..w59 complete after 52 edges.
REQ-016 For each word, temp = w[i-1], modified by i mod 8:
- i mod 8 = 0: temp = SubWord(RotWord(temp)) XOR {Rcon[i/8],00,00,00}.
- i mod 8 = 4: temp = SubWord(temp).
- w[i] = w[i-8] XOR temp.
REQ-017 Rcon[1..7] SHALL be 01,02,04,08,10,20,40 hex.
REQ-018 Key expansion SHALL always use the forward S-box, independent of inv_en.
REQ-019 key_ready SHALL rise on the edge that writes w59 and stay high until the next reset.
REQ-020 Every edge, round_key_o SHALL load {w[4r],w[4r+1],w[4r+2],w[4r+3]}, where r = round, with w[4r] in bits [127:96]. Latency is 1 cycle from round.
REQ-021 round=15 SHALL load round_key_o = 0.
REQ-022 A round key read before its words are filled returns the current table contents. Before key_ready:
- only round 0 and round 1 (w0..w7) are guaranteed valid;
- the controller SHALL NOT use any other round.
REQ-023 sb_out SHALL be the FIPS-197 S-box / inverse S-box, implemented either as a table or as GF(2^8) inversion plus affine transform.
REQ-024 For mc_in, byte s0 = mc_in[31:24] … s3 = mc_in[7:0], and output r0 goes to mc_out[31:24]. Arithmetic is GF(2^8) with polynomial 11B hex.
REQ-025 Forward mix: r0 = 2s0^3s1^s2^s3, with the coefficient row rotated right by one for each following output.
REQ-026 Inverse mix: coefficient row 0E,0B,0D,09, rotated right by one for each following output.
REQ-027 sb_out and mc_out SHALL be purely combinational and SHALL settle within the same cycle as their input.

Reset
REQ-028 Asserting rst_n low SHALL immediately clear the following:
- round_key_o = 0 and key_ready = 0;
- w8..w59 = 0;
- fill pointer = 8.
REQ-029 Reset asserted during filling SHALL abort the fill, and a full 52-cycle refill SHALL restart after release.
REQ-030 A key_in change while rst_n=1 SHALL have no effect until the next reset.

Verification
REQ-031 Key schedule, forward:
- Stimulus: key_in = 000102…1e1f; reset; wait for key_ready.
- round=0 -> round_key_o = 000102030405060708090a0b0c0d0e0f.
- round=1 -> 101112131415161718191a1b1c1d1e1f.
- round=2 -> a573c29fa176c498a97fce93a572c09c.
REQ-032 Key schedule, last round: same key, round=14 -> round_key_o = 24fc79ccbf0979e9371ac23c6d68de36 one cycle later.
REQ-033 key_ready timing: key_ready stays 0 for the first 51 edges after release and is 1 after the 52nd edge.
REQ-034 SubBytes:
- inv_en=0: sb_in 00 -> 63; 01 -> 7c; 53 -> ed.
- inv_en=1: sb_in 63 -> 00; ed -> 53.
REQ-035 Mix columns:
- inv_en=0: mc_in db135345 -> 8e4da1bc; mc_in 01010101 -> 01010101.
- inv_en=1: mc_in 8e4da1bc -> db135345.
REQ-036 Reset mid-fill: pulse rst_n low at edge 20 after release; key_ready must not be set until 52 edges after the second release, and round 14 must still read 24fc79cc….
